frame_sink_fifo: RTL and testbench

- Downstream consumer of the bouncing-squares pixel stream (sx, sy, de, sdl_r/g/b).
- Captures visible pixels frame by frame.
- Buffers them in a small synchronous FIFO and hands them to the SDL host model over a valid/ready stream tagged with start-of-frame and end-of-line.
- Frame-atomic overflow handling: on back-pressure loss it drops the rest of the frame and resyncs at the next frame start.

---
 rtl/frame_sink_fifo_pkg.sv | 22 ++
 rtl/frame_sink_fifo_if.sv | 14 +
 rtl/frame_sink_fifo_fifo_sync.sv | 51 +++++
 rtl/frame_sink_fifo.sv | 128 ++++++++++++
 tb/tb_frame_sink_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sink_fifo_pkg.sv
// Shared types for the frame sink: capture state, buffered pixel entry layout,
// and the saturation limit of the drop counter.
package frame_sink_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      CAPTURE  = 2'd1,
      DROP     = 2'd2
   } state_t;

   typedef struct packed {
      logic       sof;
      logic       eol;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_entry_t;

   localparam int          ENTRY_W  = $bits(pix_entry_t);
   localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/frame_sink_fifo_if.sv
// Output stream from the frame sink to the host model.
interface frame_sink_fifo_if;
   // Strict valid/ready: a beat transfers on any rising edge with m_valid && m_ready;
   // while m_valid && !m_ready the master holds m_data/m_sof/m_eol stable and keeps
   // m_valid high; m_valid never depends combinationally on m_ready.
   logic        m_valid;
   logic        m_ready;
   logic [23:0] m_data;
   logic        m_sof;
   logic        m_eol;

   modport master (output m_valid, output m_data, output m_sof, output m_eol, input m_ready);
   modport slave  (input m_valid, input m_data, input m_sof, input m_eol, output m_ready);
endinterface

// File: rtl/frame_sink_fifo_fifo_sync.sv
// Small synchronous FIFO; head is read straight from the storage flops, so an
// entry written at the end of cycle N is visible from cycle N+1 (no fall-through).
module fifo_sync #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full is taken from the registered count, so a pop never makes room for a same-cycle push.
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/frame_sink_fifo.sv
// Captures visible pixels frame by frame into a FIFO; on overflow the rest of
// the frame is discarded and capture resynchronises at the next frame start.
module frame_sink_fifo
   import frame_sink_pkg::*;
#(
   parameter int CORDW = 10,
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int DEPTH = 16
) (
   input  logic                     clk_pix,
   input  logic                     rst_n,
   input  logic [CORDW-1:0]         sx,
   input  logic [CORDW-1:0]         sy,
   input  logic                     de,
   input  logic [7:0]               sdl_r,
   input  logic [7:0]               sdl_g,
   input  logic [7:0]               sdl_b,
   input  logic                     capture_en,
   input  logic                     clr_ovf,
   frame_sink_fifo_if.master        m_if,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic [7:0]               frame_count,
   output state_t                   state_dbg,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
   localparam logic [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);

   logic [CORDW-1:0] sx_d, sy_d;
   logic             de_d;
   logic             pix_sof, pix_eol;
   logic             full, empty, pop;
   logic             push, drop;
   state_t           state, next_state;
   pix_entry_t       wr_e, head_e;
   logic [ENTRY_W-1:0] rd_data;

   // Colour arrives one cycle after its coordinates; delay the coordinates to match.
   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         sx_d <= '0;
         sy_d <= '0;
         de_d <= 1'b0;
      end else begin
         sx_d <= sx;
         sy_d <= sy;
         de_d <= de;
      end
   end

   assign pix_sof = de_d && (sx_d == '0) && (sy_d == '0);
   assign pix_eol = de_d && (sx_d == X_LAST);
   assign wr_e    = '{sof: pix_sof, eol: pix_eol, r: sdl_r, g: sdl_g, b: sdl_b};

   always_comb begin
      push       = 1'b0;
      drop       = 1'b0;
      next_state = state;
      unique case (state)
         CAPTURE: begin
            if (pix_sof && !capture_en) begin
               next_state = WAIT_SOF;
            end else if (de_d) begin
               if (full) begin
                  drop       = 1'b1;
                  next_state = DROP;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: begin
            // WAIT_SOF and DROP resync identically at a frame start.
            if (pix_sof) begin
               if (!capture_en) begin
                  next_state = WAIT_SOF;
               end else if (full) begin
                  drop       = 1'b1;
                  next_state = DROP;
               end else begin
                  push       = 1'b1;
                  next_state = CAPTURE;
               end
            end else if (de_d && state == DROP) begin
               drop = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         state       <= WAIT_SOF;
         overflow    <= 1'b0;
         drop_count  <= '0;
         frame_count <= '0;
      end else begin
         state <= next_state;
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         if (drop && drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
         if (push && pix_eol && sy_d == Y_LAST) frame_count <= frame_count + 1'b1;
      end
   end

   assign pop = m_if.m_valid && m_if.m_ready;

   fifo_sync #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk_pix),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (wr_e),
      .pop     (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   assign head_e      = rd_data;
   assign m_if.m_valid = !empty;
   assign m_if.m_data  = {head_e.r, head_e.g, head_e.b};
   assign m_if.m_sof   = head_e.sof;
   assign m_if.m_eol   = head_e.eol;
   assign state_dbg    = state;
endmodule

// File: tb/tb_frame_sink_fifo.sv
// Bench for frame_sink_fifo: free-running small raster, queue-based reference
// model of frame capture, and per-scenario tasks.
module tb_frame_sink_fifo;
   import frame_sink_pkg::*;

   localparam int CORDW = 10;
   localparam int H_RES = 20;
   localparam int V_RES = 6;
   localparam int DEPTH = 16;
   localparam int H_TOT = 24;
   localparam int V_TOT = 8;
   localparam int AW    = 4;

   logic             clk_pix = 1'b0;
   logic             rst_n;
   logic [CORDW-1:0] sx, sy;
   logic             de;
   logic [7:0]       sdl_r, sdl_g, sdl_b;
   logic             capture_en, clr_ovf;
   logic             overflow;
   logic [15:0]      drop_count;
   logic [7:0]       frame_count;
   state_t           state_dbg;
   logic [AW:0]      fifo_count;

   frame_sink_fifo_if m_if ();

   frame_sink_fifo #(.CORDW(CORDW), .H_RES(H_RES), .V_RES(V_RES), .DEPTH(DEPTH)) dut (
      .clk_pix     (clk_pix),
      .rst_n       (rst_n),
      .sx          (sx),
      .sy          (sy),
      .de          (de),
      .sdl_r       (sdl_r),
      .sdl_g       (sdl_g),
      .sdl_b       (sdl_b),
      .capture_en  (capture_en),
      .clr_ovf     (clr_ovf),
      .m_if        (m_if),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .frame_count (frame_count),
      .state_dbg   (state_dbg),
      .fifo_count  (fifo_count)
   );

   // clock
   always #5 clk_pix = ~clk_pix;

   int tests = 0;
   int fails = 0;

   // reference model: expected FIFO contents and status
   logic [25:0] exp_q[$];
   bit          mdl_ovf;
   int          mdl_drop, mdl_frames;
   bit          mdl_in_frame, mdl_lost;

   // raster generator
   int          cur_x, cur_y, d_x, d_y;
   bit          cur_de, d_de;
   logic [23:0] col_now, col_next;
   bit          rst_req, clr_req, en_req, checking, pat_mode;
   int          ready_pct;

   // statistics from observed DUT pops
   int          popped, sof_seen, eol_seen, line_idx, first_red;
   bit          first_pop_sof;

   function automatic logic [23:0] pick_colour(int x, int y);
      if (pat_mode)
         return (x >= 10 && x < 14 && y >= 1 && y < 5) ? 24'hFF0000 : 24'h000080;
      return 24'($urandom());
   endfunction

   task automatic clear_stats();
      popped = 0; sof_seen = 0; eol_seen = 0; line_idx = 0; first_red = -1; first_pop_sof = 0;
   endtask

   task automatic tick();
      bit will_pop, wr, lose, is_sof, is_eol, rst_edge;
      @(negedge clk_pix);
      will_pop = (exp_q.size() != 0) && m_if.m_ready;
      if (checking) begin
         tests++;
         if (m_if.m_valid !== (exp_q.size() != 0)) begin
            fails++; $display("FAIL m_valid: got %b expected %b", m_if.m_valid, exp_q.size() != 0);
         end
         tests++;
         if (fifo_count !== 5'(exp_q.size())) begin
            fails++; $display("FAIL fifo_count: got %0d expected %0d", fifo_count, exp_q.size());
         end
         tests++;
         if (overflow !== mdl_ovf) begin
            fails++; $display("FAIL overflow: got %b expected %b", overflow, mdl_ovf);
         end
         tests++;
         if (drop_count !== 16'(mdl_drop)) begin
            fails++; $display("FAIL drop_count: got %0d expected %0d", drop_count, mdl_drop);
         end
         tests++;
         if (frame_count !== 8'(mdl_frames)) begin
            fails++; $display("FAIL frame_count: got %0d expected %0d", frame_count, mdl_frames);
         end
         if (exp_q.size() != 0) begin
            tests++;
            if ({m_if.m_sof, m_if.m_eol, m_if.m_data} !== exp_q[0]) begin
               fails++;
               $display("FAIL head: got %h expected %h", {m_if.m_sof, m_if.m_eol, m_if.m_data}, exp_q[0]);
            end
         end
         if (m_if.m_valid && m_if.m_ready) begin
            if (popped == 0) first_pop_sof = m_if.m_sof;
            popped++;
            sof_seen += int'(m_if.m_sof);
            eol_seen += int'(m_if.m_eol);
            if (pat_mode && first_red < 0 && m_if.m_data[23:16] == 8'hFF) first_red = line_idx;
            line_idx = m_if.m_eol ? 0 : line_idx + 1;
         end
      end
      // capture rules applied to the pixel whose colour is on sdl_* now
      wr = 0; lose = 0;
      is_sof = d_de && d_x == 0 && d_y == 0;
      is_eol = d_de && d_x == H_RES - 1;
      if (is_sof) begin
         if (!capture_en) begin
            mdl_in_frame = 0; mdl_lost = 0;
         end else if (exp_q.size() < DEPTH) begin
            wr = 1; mdl_in_frame = 1; mdl_lost = 0;
         end else begin
            lose = 1; mdl_in_frame = 0; mdl_lost = 1;
         end
      end else if (d_de) begin
         if (mdl_in_frame) begin
            if (exp_q.size() < DEPTH) wr = 1;
            else begin lose = 1; mdl_in_frame = 0; mdl_lost = 1; end
         end else if (mdl_lost) begin
            lose = 1;
         end
      end
      @(posedge clk_pix);
      rst_edge = !rst_n;
      if (rst_edge) begin
         exp_q.delete();
         mdl_ovf = 0; mdl_drop = 0; mdl_frames = 0; mdl_in_frame = 0; mdl_lost = 0;
      end else begin
         if (will_pop) void'(exp_q.pop_front());
         if (wr) begin
            exp_q.push_back({is_sof, is_eol, col_now});
            if (is_eol && d_y == V_RES - 1) mdl_frames = (mdl_frames + 1) % 256;
         end
         if (lose) begin
            mdl_ovf = 1;
            if (mdl_drop < 65535) mdl_drop++;
         end else if (clr_ovf) begin
            mdl_ovf = 0;
         end
      end
      #1;
      d_x = cur_x; d_y = cur_y; d_de = rst_edge ? 1'b0 : cur_de;
      col_now = col_next;
      cur_x++;
      if (cur_x == H_TOT) begin cur_x = 0; cur_y = (cur_y + 1) % V_TOT; end
      cur_de   = (cur_x < H_RES) && (cur_y < V_RES);
      col_next = pick_colour(cur_x, cur_y);
      sx = CORDW'(cur_x); sy = CORDW'(cur_y); de = cur_de;
      {sdl_r, sdl_g, sdl_b} = col_now;
      rst_n = !rst_req; clr_ovf = clr_req; capture_en = en_req;
      m_if.m_ready = ($urandom_range(0, 99) < ready_pct);
   endtask

   task automatic run_until(int tx, int ty);
      int n = 0;
      while (!(cur_x == tx && cur_y == ty) && n < H_TOT * V_TOT + 2) begin tick(); n++; end
      tests++;
      if (!(cur_x == tx && cur_y == ty)) begin
         fails++; $display("FAIL run_until: at (%0d,%0d) expected (%0d,%0d)", cur_x, cur_y, tx, ty);
      end
   endtask

   task automatic frame();
      tick();
      run_until(0, 0);
   endtask

   task automatic do_reset();
      rst_req = 1; tick();
      rst_req = 0; tick();
   endtask

   task automatic chk(string name, int got, int exp);
      tests++;
      if (got != exp) begin fails++; $display("FAIL %s: got %0d expected %0d", name, got, exp); end
   endtask

   task automatic test_reset();
      rst_req = 1; en_req = 0; ready_pct = 100;
      repeat (3) tick();
      rst_req = 0; tick();
      checking = 1;
      chk("reset_m_valid", int'(m_if.m_valid), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_drop_count", int'(drop_count), 0);
      chk("reset_frame_count", int'(frame_count), 0);
      chk("reset_state", int'(state_dbg == WAIT_SOF), 1);
   endtask

   task automatic test_two_frames();
      en_req = 1; ready_pct = 100;
      run_until(0, 0);
      clear_stats();
      frame(); frame();
      en_req = 0;
      repeat (2) tick();
      chk("two_frames_entries", popped, 2 * H_RES * V_RES);
      chk("two_frames_sof", sof_seen, 2);
      chk("two_frames_eol", eol_seen, 2 * V_RES);
      chk("two_frames_frame_count", int'(frame_count), 2);
      chk("two_frames_overflow", int'(overflow), 0);
      chk("two_frames_drop_count", int'(drop_count), 0);
   endtask

   task automatic test_midframe_enable();
      en_req = 0; ready_pct = 100;
      run_until(0, 0); tick();
      run_until(0, 3);
      en_req = 1;
      clear_stats();
      run_until(0, 0);
      chk("midframe_no_entries", popped, 0);
      repeat (4) tick();
      chk("midframe_got_entry", int'(popped > 0), 1);
      chk("midframe_first_sof", int'(first_pop_sof), 1);
   endtask

   task automatic test_backpressure();
      do_reset();
      en_req = 1; ready_pct = 0;
      run_until(0, 0);
      clear_stats();
      run_until(0, 1);
      chk("bp_held", int'(fifo_count), DEPTH);
      chk("bp_overflow", int'(overflow), 1);
      chk("bp_drop_line0", int'(drop_count), H_RES - DEPTH);
      chk("bp_no_pops", popped, 0);
      ready_pct = 100;
      run_until(0, 0);
      chk("bp_drained", popped, DEPTH);
      chk("bp_drop_frame", int'(drop_count), H_RES * V_RES - DEPTH);
      clear_stats();
      frame();
      repeat (2) tick();
      chk("bp_next_frame_entries", popped, H_RES * V_RES);
      chk("bp_next_frame_sof", sof_seen, 1);
      chk("bp_frame_count", int'(frame_count), 1);
   endtask

   task automatic test_colour_align();
      do_reset();
      pat_mode = 1; en_req = 1; ready_pct = 100;
      run_until(0, 0);
      clear_stats();
      frame();
      repeat (2) tick();
      chk("colour_first_red_idx", first_red, 10);
      pat_mode = 0;
   endtask

   task automatic test_clr_ovf();
      do_reset();
      en_req = 1; ready_pct = 0;
      run_until(0, 0);
      run_until(5, 1);
      clr_req = 1; tick();
      clr_req = 0; tick();
      chk("clr_with_drop_overflow", int'(overflow), 1);
      run_until(H_RES + 1, 1);
      clr_req = 1; tick();
      clr_req = 0; tick();
      chk("clr_alone_overflow", int'(overflow), 0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      en_req = 1; ready_pct = 0;
      run_until(0, 0);
      run_until(5, 0);
      rst_req = 1; tick();
      chk("rmid_buffered", int'(fifo_count), 5);
      rst_req = 0; tick();
      chk("rmid_m_valid", int'(m_if.m_valid), 0);
      chk("rmid_count", int'(fifo_count), 0);
      chk("rmid_overflow", int'(overflow), 0);
      chk("rmid_drop_count", int'(drop_count), 0);
      chk("rmid_frame_count", int'(frame_count), 0);
      ready_pct = 100;
      clear_stats();
      run_until(0, 0);
      chk("rmid_quiet_until_sof", popped, 0);
      clear_stats();
      frame();
      repeat (2) tick();
      chk("rmid_next_frame", popped, H_RES * V_RES);
   endtask

   task automatic test_random();
      do_reset();
      for (int f = 0; f < 6; f++) begin
         ready_pct = $urandom_range(30, 100);
         en_req    = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < H_TOT * V_TOT; i++) begin
            clr_req = ($urandom_range(0, 15) == 0);
            tick();
         end
      end
      clr_req = 0; en_req = 0; ready_pct = 100;
      repeat (DEPTH + 4) tick();
      chk("random_drained", int'(m_if.m_valid), 0);
   endtask

   initial begin
      rst_n = 0; sx = '0; sy = '0; de = 0; sdl_r = '0; sdl_g = '0; sdl_b = '0;
      capture_en = 0; clr_ovf = 0; m_if.m_ready = 0;
      cur_x = H_RES + 2; cur_y = 2; cur_de = 0; d_x = 0; d_y = 0; d_de = 0;
      col_now = '0; col_next = '0;
      rst_req = 1; clr_req = 0; en_req = 0; checking = 0; pat_mode = 0; ready_pct = 100;
      mdl_ovf = 0; mdl_drop = 0; mdl_frames = 0; mdl_in_frame = 0; mdl_lost = 0;
      clear_stats();
      test_reset();
      test_two_frames();
      test_midframe_enable();
      test_backpressure();
      test_colour_align();
      test_clr_ovf();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
